// File: rtl/fp2int_pipe.sv
// fp2int_pipe: three-stage float-to-integer converter (DP or SP in, int32/int64 out).
// Stage 1 unpacks and classifies, stage 2 aligns the mantissa, stage 3 rounds,
// range-checks, saturates and raises flags. All stages hold together when the
// output is stalled.
// Build option: define FP2INT_DENORM_FLUSH_EN to flush subnormal inputs to zero.
module fp2int_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] op1,
  input  logic [1:0]  P,
  input  logic [2:0]  rm,
  input  logic [1:0]  op_type,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] IntResult,
  output logic [4:0]  Flags,
  output logic        Denorm
);

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // ---------------- Stage 1: unpack / classify ----------------
  logic               sign_next, nan_next, inf_next, sub_next, big_next;
  logic [63:0]        mant_next;
  logic [6:0]         shift_next;
  logic               exp_all_ones, exp_zero, frac_nz;
  logic [11:0]        exp_eff, bias63;
  logic signed [13:0] shift_full;

  // Decode the operand into a 64-bit mantissa (leading 1 at bit 63) and a right-shift amount.
  always_comb begin
    if (P[0]) begin
      sign_next    = op1[31];
      exp_all_ones = &op1[30:23];
      exp_zero     = ~|op1[30:23];
      frac_nz      = |op1[22:0];
      mant_next    = {~exp_zero, op1[22:0], 40'd0};
      exp_eff      = exp_zero ? 12'd1 : {4'd0, op1[30:23]};
      bias63       = 12'd190;
    end else begin
      sign_next    = op1[63];
      exp_all_ones = &op1[62:52];
      exp_zero     = ~|op1[62:52];
      frac_nz      = |op1[51:0];
      mant_next    = {~exp_zero, op1[51:0], 11'd0};
      exp_eff      = exp_zero ? 12'd1 : {1'b0, op1[62:52]};
      bias63       = 12'd1086;
    end
    // A negative shift means the magnitude is at least 2^64: out of range for every target.
    shift_full = $signed({2'b00, bias63}) - $signed({2'b00, exp_eff});
    big_next   = shift_full[13];
    if (big_next)
      shift_next = 7'd0;
    else if (shift_full > 14'sd127)
      shift_next = 7'd127;
    else
      shift_next = shift_full[6:0];
    nan_next = exp_all_ones & frac_nz;
    inf_next = exp_all_ones & ~frac_nz;
    sub_next = exp_zero & frac_nz;
`ifdef FP2INT_DENORM_FLUSH_EN
    if (sub_next)
      mant_next = 64'd0;
`endif
  end

  logic        v1_reg, sign1_reg, nan1_reg, inf1_reg, sub1_reg, big1_reg, rsv1_reg;
  logic [63:0] mant1_reg;
  logic [6:0]  shift1_reg;
  logic [2:0]  rm1_reg;
  logic [1:0]  type1_reg;

  // Stage 1 register; captures a new operand whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg     <= 1'b0;
      sign1_reg  <= 1'b0;
      nan1_reg   <= 1'b0;
      inf1_reg   <= 1'b0;
      sub1_reg   <= 1'b0;
      big1_reg   <= 1'b0;
      rsv1_reg   <= 1'b0;
      mant1_reg  <= 64'd0;
      shift1_reg <= 7'd0;
      rm1_reg    <= 3'd0;
      type1_reg  <= 2'd0;
    end else if (advance) begin
      v1_reg     <= in_valid;
      sign1_reg  <= sign_next;
      nan1_reg   <= nan_next;
      inf1_reg   <= inf_next;
      sub1_reg   <= sub_next;
      big1_reg   <= big_next;
      rsv1_reg   <= P[1];
      mant1_reg  <= mant_next;
      shift1_reg <= shift_next;
      rm1_reg    <= rm;
      type1_reg  <= op_type;
    end
  end

  // ---------------- Stage 2: align ----------------
  // A 191-bit window keeps every shifted-out bit, so guard and sticky are exact even at shift 127.
  logic [190:0] shifted;
  assign shifted = {mant1_reg, 127'd0} >> shift1_reg;

  logic        v2_reg, sign2_reg, nan2_reg, inf2_reg, sub2_reg, big2_reg, rsv2_reg;
  logic        guard2_reg, sticky2_reg;
  logic [63:0] int2_reg;
  logic [2:0]  rm2_reg;
  logic [1:0]  type2_reg;

  // Stage 2 register: integer part plus guard/sticky of the aligned mantissa.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_reg      <= 1'b0;
      sign2_reg   <= 1'b0;
      nan2_reg    <= 1'b0;
      inf2_reg    <= 1'b0;
      sub2_reg    <= 1'b0;
      big2_reg    <= 1'b0;
      rsv2_reg    <= 1'b0;
      guard2_reg  <= 1'b0;
      sticky2_reg <= 1'b0;
      int2_reg    <= 64'd0;
      rm2_reg     <= 3'd0;
      type2_reg   <= 2'd0;
    end else if (advance) begin
      v2_reg      <= v1_reg;
      sign2_reg   <= sign1_reg;
      nan2_reg    <= nan1_reg;
      inf2_reg    <= inf1_reg;
      sub2_reg    <= sub1_reg;
      big2_reg    <= big1_reg;
      rsv2_reg    <= rsv1_reg;
      guard2_reg  <= shifted[126];
      sticky2_reg <= |shifted[125:0];
      int2_reg    <= shifted[190:127];
      rm2_reg     <= rm1_reg;
      type2_reg   <= type1_reg;
    end
  end

  // ---------------- Stage 3: round / range / saturate ----------------
  logic        inc, oor, invalid, inexact, denorm_next;
  logic [64:0] mag;
  logic [63:0] max_val, min_val, signed_val, result_next;

  // Round the magnitude, check it against the target range and pick the final value.
  always_comb begin
    inc = 1'b0;
    case (rm2_reg)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign2_reg & (guard2_reg | sticky2_reg);
      3'b011:  inc = ~sign2_reg & (guard2_reg | sticky2_reg);
      3'b100:  inc = guard2_reg;
      default: inc = guard2_reg & (sticky2_reg | int2_reg[0]);
    endcase
    mag     = {1'b0, int2_reg} + {64'd0, inc};
    oor     = 1'b0;
    max_val = 64'hFFFF_FFFF_FFFF_FFFF;
    min_val = 64'd0;
    case (type2_reg)
      2'b00: begin
        oor     = sign2_reg ? (mag > 65'h0_8000_0000_0000_0000) : (mag[64] | mag[63]);
        max_val = 64'h7FFF_FFFF_FFFF_FFFF;
        min_val = 64'h8000_0000_0000_0000;
      end
      2'b01: oor = sign2_reg ? (mag != 65'd0) : mag[64];
      2'b10: begin
        oor     = sign2_reg ? (mag > 65'h0_0000_0000_8000_0000) : (|mag[64:31]);
        max_val = 64'h0000_0000_7FFF_FFFF;
        min_val = 64'hFFFF_FFFF_8000_0000;
      end
      default: oor = sign2_reg ? (mag != 65'd0) : (|mag[64:32]);
    endcase
    invalid    = rsv2_reg | nan2_reg | inf2_reg | big2_reg | oor;
    signed_val = sign2_reg ? (~mag[63:0] + 64'd1) : mag[63:0];
    // int32 results of either signedness are sign-extended from bit 31.
    if (type2_reg[1])
      signed_val = {{32{signed_val[31]}}, signed_val[31:0]};
    if (rsv2_reg)
      result_next = 64'd0;
    else if (invalid)
      result_next = (nan2_reg | ~sign2_reg) ? max_val : min_val;
    else
      result_next = signed_val;
    inexact     = ~invalid & (guard2_reg | sticky2_reg);
    denorm_next = sub2_reg & ~rsv2_reg;
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      IntResult <= 64'd0;
      Flags     <= 5'd0;
      Denorm    <= 1'b0;
    end else if (advance) begin
      out_valid <= v2_reg;
      IntResult <= result_next;
      Flags     <= {invalid, 3'b000, inexact};
      Denorm    <= denorm_next;
    end
  end

endmodule

// File: tb/tb_fp2int_pipe.sv
// tb_fp2int_pipe: directed vectors with literal expectations, a value-level
// reference model (exact remainder vs half comparison), and a scoreboard that
// checks every output transfer. Honours FP2INT_DENORM_FLUSH_EN like the design.
module tb_fp2int_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, Denorm;
  logic [63:0] op1, IntResult;
  logic [1:0]  P, op_type;
  logic [2:0]  rm;
  logic [4:0]  Flags;

  always #5 clk = ~clk;

  fp2int_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .P(P), .rm(rm), .op_type(op_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .IntResult(IntResult), .Flags(Flags), .Denorm(Denorm)
  );

  typedef struct packed {
    logic [63:0] op;
    logic [1:0]  p;
    logic [2:0]  rm;
    logic [1:0]  ot;
    logic [63:0] res;
    logic [4:0]  fl;
    logic        dn;
  } vec_t;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  fl;
    logic        dn;
  } exp_t;

  vec_t vecs[$];
  exp_t mexp[$];
  exp_t expq[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   ntx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void add(input logic [63:0] op, input logic [1:0] p, input logic [2:0] r,
                              input logic [1:0] ot, input logic [63:0] res, input logic [4:0] fl,
                              input logic dn);
    vec_t v;
    v.op = op; v.p = p; v.rm = r; v.ot = ot; v.res = res; v.fl = fl; v.dn = dn;
    vecs.push_back(v);
  endfunction

  // Reference: value = m * 2^e exactly; round by comparing the dropped fraction with one half.
  task automatic model(input logic [63:0] op, input logic [1:0] p, input logic [2:0] rmode,
                       input logic [1:0] ot, output logic [63:0] res, output logic [4:0] fl,
                       output logic dn);
    logic               s, is_max, exact, up;
    logic [51:0]        f;
    logic [127:0]       m, ip, fr, half, r;
    logic signed [129:0] vv, lo, hi, one;
    logic [63:0]        maxv, minv;
    int                 ex, e_unb, ne, cmp;
    res = 64'd0; fl = 5'd0; dn = 1'b0;
    one = 130'sd1;
    case (ot)
      2'd0: begin lo = -(one <<< 63); hi = (one <<< 63) - one;
                  maxv = 64'h7FFF_FFFF_FFFF_FFFF; minv = 64'h8000_0000_0000_0000; end
      2'd1: begin lo = 130'sd0; hi = (one <<< 64) - one; maxv = '1; minv = 64'd0; end
      2'd2: begin lo = -(one <<< 31); hi = (one <<< 31) - one;
                  maxv = 64'h0000_0000_7FFF_FFFF; minv = 64'hFFFF_FFFF_8000_0000; end
      default: begin lo = 130'sd0; hi = (one <<< 32) - one; maxv = '1; minv = 64'd0; end
    endcase
    if (p[1]) begin
      fl = 5'h10;
      return;
    end
    if (p == 2'b00) begin
      s = op[63]; ex = int'(op[62:52]); f = op[51:0]; is_max = (ex == 2047);
      m = (ex == 0) ? {76'd0, f} : ({76'd0, f} | (128'd1 << 52));
      e_unb = ((ex == 0) ? 1 : ex) - 1075;
    end else begin
      s = op[31]; ex = int'(op[30:23]); f = {29'd0, op[22:0]}; is_max = (ex == 255);
      m = (ex == 0) ? {76'd0, f} : ({76'd0, f} | (128'd1 << 23));
      e_unb = ((ex == 0) ? 1 : ex) - 150;
    end
    dn = (ex == 0) && (f != 52'd0);
    if (is_max) begin
      fl = 5'h10;
      res = ((f != 52'd0) || !s) ? maxv : minv;
      return;
    end
`ifdef FP2INT_DENORM_FLUSH_EN
    if (dn) return;
`endif
    if (m == 128'd0) return;
    if (e_unb > 64) begin
      fl = 5'h10;
      res = s ? minv : maxv;
      return;
    end
    if (e_unb >= 0) begin
      ip = m << e_unb; exact = 1'b1; cmp = -1;
    end else begin
      ne = -e_unb;
      if (ne > 120) begin
        ip = 128'd0; exact = 1'b0; cmp = -1;
      end else begin
        ip = m >> ne;
        fr = m - (ip << ne);
        half = 128'd1 << (ne - 1);
        exact = (fr == 128'd0);
        cmp = (fr < half) ? -1 : ((fr == half) ? 0 : 1);
      end
    end
    case (rmode)
      3'd1: up = 1'b0;
      3'd2: up = s && !exact;
      3'd3: up = !s && !exact;
      3'd4: up = (cmp >= 0);
      default: up = (cmp > 0) || (cmp == 0 && ip[0]);
    endcase
    r = ip + {127'd0, up};
    vv = $signed({2'b00, r});
    if (s) vv = -vv;
    if (vv < lo || vv > hi) begin
      fl = 5'h10;
      res = s ? minv : maxv;
    end else begin
      res = vv[63:0];
      if (ot[1]) res = {{32{vv[31]}}, vv[31:0]};
      fl = exact ? 5'h00 : 5'h01;
    end
  endtask

  // Scoreboard: every output transfer is checked against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        cur = expq.pop_front();
        check("result", IntResult, cur.res);
        check("flags", 64'(Flags), 64'(cur.fl));
        check("denorm", 64'(Denorm), 64'(cur.dn));
        $display("txn %0d: result=%h flags=%h denorm=%b", ntx, IntResult, Flags, Denorm);
        ntx++;
      end
    end
  end

  task automatic send(input int i);
    bit acc;
    acc = 1'b0;
    op1 = vecs[i].op; P = vecs[i].p; rm = vecs[i].rm; op_type = vecs[i].ot;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) expq.push_back(mexp[i]);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [63:0] r64, snap_res;
    logic [4:0]  rfl, snap_fl;
    logic        rdn, snap_dn;
    exp_t        e;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op1 = 64'd0; P = 2'd0; rm = 3'd0; op_type = 2'd0;

    add(64'h3FF8000000000000, 2'd0, 3'd0, 2'd0, 64'd2, 5'h01, 1'b0);
    add(64'h4004000000000000, 2'd0, 3'd0, 2'd0, 64'd2, 5'h01, 1'b0);
    add(64'hC004000000000000, 2'd0, 3'd4, 2'd0, 64'hFFFF_FFFF_FFFF_FFFD, 5'h01, 1'b0);
    add(64'h000000004F000000, 2'd1, 3'd0, 2'd2, 64'h0000_0000_7FFF_FFFF, 5'h10, 1'b0);
    add(64'h7FF8000000000000, 2'd0, 3'd0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'h10, 1'b0);
    add(64'hBFD3333333333333, 2'd0, 3'd1, 2'd1, 64'd0, 5'h01, 1'b0);
    add(64'hBFF8000000000000, 2'd0, 3'd1, 2'd1, 64'd0, 5'h10, 1'b0);
`ifdef FP2INT_DENORM_FLUSH_EN
    add(64'h0000000000000001, 2'd0, 3'd3, 2'd0, 64'd0, 5'h00, 1'b1);
    add(64'h0000000080000001, 2'd1, 3'd2, 2'd0, 64'd0, 5'h00, 1'b1);
`else
    add(64'h0000000000000001, 2'd0, 3'd3, 2'd0, 64'd1, 5'h01, 1'b1);
    add(64'h0000000080000001, 2'd1, 3'd2, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'h01, 1'b1);
`endif
    add(64'h000000004F800000, 2'd1, 3'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'h10, 1'b0);
    add(64'h000000004F7FFFFF, 2'd1, 3'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FF00, 5'h00, 1'b0);
    add(64'hC3E0000000000000, 2'd0, 3'd0, 2'd0, 64'h8000_0000_0000_0000, 5'h00, 1'b0);
    add(64'h43E0000000000000, 2'd0, 3'd0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 5'h10, 1'b0);
    add(64'h43E0000000000000, 2'd0, 3'd0, 2'd1, 64'h8000_0000_0000_0000, 5'h00, 1'b0);
    add(64'h8000000000000000, 2'd0, 3'd0, 2'd0, 64'd0, 5'h00, 1'b0);
    add(64'h7FF0000000000000, 2'd0, 3'd0, 2'd2, 64'h0000_0000_7FFF_FFFF, 5'h10, 1'b0);
    add(64'hFFF0000000000000, 2'd0, 3'd0, 2'd3, 64'd0, 5'h10, 1'b0);
    add(64'h3FF0000000000000, 2'd2, 3'd0, 2'd0, 64'd0, 5'h10, 1'b0);
    add(64'h3FE0000000000000, 2'd0, 3'd0, 2'd0, 64'd0, 5'h01, 1'b0);
    add(64'h3FE0000000000000, 2'd0, 3'd3, 2'd0, 64'd1, 5'h01, 1'b0);
    add(64'hBFE0000000000000, 2'd0, 3'd2, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'h01, 1'b0);
    add(64'h4008000000000000, 2'd0, 3'd0, 2'd0, 64'd3, 5'h00, 1'b0);
    add(64'hC1E0000000000000, 2'd0, 3'd0, 2'd2, 64'hFFFF_FFFF_8000_0000, 5'h00, 1'b0);
    add(64'hC1E0000000200000, 2'd0, 3'd0, 2'd2, 64'hFFFF_FFFF_8000_0000, 5'h10, 1'b0);
    add(64'h4004000000000000, 2'd0, 3'd3, 2'd0, 64'd3, 5'h01, 1'b0);
    add(64'hDEADBEEF3FC00000, 2'd1, 3'd0, 2'd2, 64'd2, 5'h01, 1'b0);
    add(64'h4004000000000000, 2'd0, 3'd5, 2'd0, 64'd2, 5'h01, 1'b0);
    add(64'h3FF8000000000000, 2'd0, 3'd0, 2'd3, 64'd2, 5'h01, 1'b0);
    add(64'h41EFFFFFFFE00000, 2'd0, 3'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'h00, 1'b0);
    add(64'h000000007FC00000, 2'd1, 3'd0, 2'd2, 64'h0000_0000_7FFF_FFFF, 5'h10, 1'b0);

    // Pin the model against the hand-computed literals, then keep its answers for the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      model(vecs[i].op, vecs[i].p, vecs[i].rm, vecs[i].ot, r64, rfl, rdn);
      check($sformatf("model_res_%0d", i), r64, vecs[i].res);
      check($sformatf("model_flags_%0d", i), 64'(rfl), 64'(vecs[i].fl));
      check($sformatf("model_denorm_%0d", i), 64'(rdn), 64'(vecs[i].dn));
      e.res = r64; e.fl = rfl; e.dn = rdn;
      mexp.push_back(e);
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", IntResult, 64'd0);
    check("rst_flags", 64'(Flags), 64'd0);
    check("rst_denorm", 64'(Denorm), 64'd0);
    reset = 1'b0;

    // Latency: out_valid appears after the third rising edge counted from acceptance.
    send(0);
    @(negedge clk); check("lat_edge1", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_edge2", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_edge3", 64'(out_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    // Stall: three ops fill the pipe with out_ready low, a fourth waits for five cycles.
    out_ready = 1'b0;
    send(1); send(2); send(3);
    op1 = vecs[4].op; P = vecs[4].p; rm = vecs[4].rm; op_type = vecs[4].ot;
    in_valid = 1'b1;
    @(negedge clk);
    snap_res = IntResult; snap_fl = Flags; snap_dn = Denorm;
    check("stall_head", snap_res, mexp[1].res);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_hold_res", IntResult, snap_res);
      check("stall_hold_flags", 64'({Flags, Denorm}), 64'({snap_fl, snap_dn}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4); send(5); send(6);

    // Reset while stalled with work in flight drops everything.
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midstall_rst_valid", 64'(out_valid), 64'd0);
    check("midstall_rst_result", IntResult, 64'd0);
    check("midstall_rst_flags", 64'({Flags, Denorm}), 64'd0);
    expq.delete();
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Stream the remaining vectors back to back.
    for (int i = 7; i < vecs.size(); i++) send(i);

    for (int c = 0; c < 100 && expq.size() > 0; c++) @(posedge clk);
    #1;
    check("drain_left", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
